// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches Pattern/Count, shifts Pattern MSB-first Count times, then pulses Done.
// Optional feature macro SEQ_TX_GAP_EN inserts GAP idle cycles between consecutive repeats.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [CNT_W-1:0] Count,
    output logic             Ready,
    output logic             Out,
    output logic             Out_valid,
    output logic             Done,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BIT_W = $clog2(PAT_W);

`ifdef SEQ_TX_GAP_EN
    localparam bit GAP_ON = (GAP > 0);
    localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GAP_CW-1:0] r_gap_cnt;
`else
    // GAP is accepted for interface compatibility but has no effect here
    localparam bit GAP_ON = 1'b0 && (GAP >= 0);
`endif

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_rep;
    logic               r_out;
    logic               r_out_valid;
    logic               r_done;

    logic               w_last_bit;
    logic [CNT_W-1:0]   w_rep_dec;
    logic               w_last_rep;
    logic               w_accept;

    assign w_last_bit = (r_bit_cnt == {BIT_W{1'b0}});
    assign w_rep_dec  = r_rep - CNT_W'(1'b1);
    assign w_last_rep = (w_rep_dec == {CNT_W{1'b0}});
    assign w_accept   = Start && (Count != {CNT_W{1'b0}});

    // Main FSM: r_out always holds the bit to be presented after this edge
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_pat       <= {PAT_W{1'b0}};
            r_shift     <= {PAT_W{1'b0}};
            r_bit_cnt   <= {BIT_W{1'b0}};
            r_rep       <= {CNT_W{1'b0}};
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQ_TX_GAP_EN
            r_gap_cnt   <= {GAP_CW{1'b0}};
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pat       <= Pattern;
                        r_rep       <= Count;
                        r_out       <= Pattern[PAT_W-1];
                        r_shift     <= {Pattern[PAT_W-2:0], 1'b0};
                        r_bit_cnt   <= BIT_W'(PAT_W - 1);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end else begin
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last_bit) begin
                        r_out     <= r_shift[PAT_W-1];
                        r_shift   <= {r_shift[PAT_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - BIT_W'(1'b1);
                    end else if (w_last_rep) begin
                        r_rep       <= {CNT_W{1'b0}};
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (GAP_ON) begin
                        r_rep       <= w_rep_dec;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_GAP;
`ifdef SEQ_TX_GAP_EN
                        r_gap_cnt   <= GAP_CW'(GAP - 1);
`endif
                    end else begin
                        // back-to-back repeat: reload without a bubble
                        r_rep     <= w_rep_dec;
                        r_out     <= r_pat[PAT_W-1];
                        r_shift   <= {r_pat[PAT_W-2:0], 1'b0};
                        r_bit_cnt <= BIT_W'(PAT_W - 1);
                    end
                end
`ifdef SEQ_TX_GAP_EN
                ST_GAP: begin
                    if (r_gap_cnt == {GAP_CW{1'b0}}) begin
                        r_out       <= r_pat[PAT_W-1];
                        r_shift     <= {r_pat[PAT_W-2:0], 1'b0};
                        r_bit_cnt   <= BIT_W'(PAT_W - 1);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end else begin
                        r_gap_cnt   <= r_gap_cnt - GAP_CW'(1'b1);
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pat       <= {PAT_W{1'b0}};
                    r_shift     <= {PAT_W{1'b0}};
                    r_bit_cnt   <= {BIT_W{1'b0}};
                    r_rep       <= {CNT_W{1'b0}};
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign Ready     = (r_state == ST_IDLE);
    assign Out       = r_out;
    assign Out_valid = r_out_valid;
    assign Done      = r_done;
    assign state     = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected bits/Done with their cycle; a monitor pops and compares.
module tb_seq_pattern_tx;
    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP   = 1;
`ifdef SEQ_TX_GAP_EN
    localparam int G = GAP;
`else
    localparam int G = 0;
`endif

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Start = 1'b0;
    logic [PAT_W-1:0] Pattern = 4'b0000;
    logic [CNT_W-1:0] Count = 4'b0000;
    logic             Ready, Out, Out_valid, Done;
    logic [1:0]       state;

    typedef struct {
        bit is_done;
        bit val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   gap_seen = 0;
    int   det = 0;
    int   n_valid = 0;
    int   n_done = 0;
    logic [3:0] hist = 4'b0000;
    int   hist_n = 0;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Pattern(Pattern), .Count(Count),
        .Ready(Ready), .Out(Out), .Out_valid(Out_valid), .Done(Done), .state(state)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a bit or Done
    always @(negedge Clk) begin
        exp_t e;
        if (Rst === 1'b1) begin
            if (state == 2'd2) gap_seen++;
            if (Done) n_done++;
            if (Out_valid) begin
                n_valid++;
                hist = {hist[2:0], Out};
                hist_n++;
                if (hist_n >= 4 && hist == 4'b1010) begin
                    det++;
                    hist_n = 0;
                end
            end
            if (Out_valid || Done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: Out=%0b Out_valid=%0b Done=%0b at cycle %0d, expected no output",
                             Out, Out_valid, Done, cyc);
                end else begin
                    e = q.pop_front();
                    check("done_flag", {31'd0, Done}, {31'd0, e.is_done});
                    check("out_valid", {31'd0, Out_valid}, {31'd0, ~e.is_done});
                    check("out_bit", {31'd0, Out}, {31'd0, e.val});
                    check("out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic start_xfer(input logic [3:0] pat, input logic [3:0] cnt, output int ce);
        int n;
        n = 0;
        while (!Ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("ready_before_start", {31'd0, Ready}, 32'd1);
        Pattern = pat;
        Count   = cnt;
        Start   = 1'b1;
        ce      = cyc;
        for (int r = 0; r < int'(cnt); r++)
            for (int k = 0; k < PAT_W; k++)
                q.push_back('{1'b0, pat[PAT_W-1-k], ce + 1 + r * (PAT_W + G) + k});
        if (cnt != 4'd0)
            q.push_back('{1'b1, 1'b0, ce + 1 + int'(cnt) * PAT_W + (int'(cnt) - 1) * G});
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || !Ready) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check(name, {31'd0, (n < 400)}, 32'd1);
    endtask

    initial begin
        int ce, dc, d0, g0, v0, n0;
        // reset state
        #12;
        check("rst_ready", {31'd0, Ready}, 32'd1);
        check("rst_out", {31'd0, Out}, 32'd0);
        check("rst_valid", {31'd0, Out_valid}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        #1 Rst = 1'b1;
        @(negedge Clk);

        // 1010 x3: back-to-back (or gapped when the feature is built)
        d0 = det; g0 = gap_seen;
        start_xfer(4'b1010, 4'd3, ce);
        dc = ce + 1 + 3 * PAT_W + 2 * G;
        while (cyc < dc) @(negedge Clk);
        check("done_at_end", {31'd0, Done}, 32'd1);
        check("ready_low_in_done", {31'd0, Ready}, 32'd0);
        @(negedge Clk);
        check("ready_after_done", {31'd0, Ready}, 32'd1);
        check("done_one_cycle", {31'd0, Done}, 32'd0);
        wait_idle("idle_t1");
        check("detections_1010", det - d0, 32'd3);
        check("gap_cycles", gap_seen - g0, 2 * G);

        // Count=0 is ignored
        Pattern = 4'b1111; Count = 4'd0; Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("cnt0_ready", {31'd0, Ready}, 32'd1);
            check("cnt0_valid", {31'd0, Out_valid}, 32'd0);
            check("cnt0_done", {31'd0, Done}, 32'd0);
        end
        Start = 1'b0;

        // Start and Pattern change during SHIFT have no effect
        start_xfer(4'b1010, 4'd2, ce);
        @(negedge Clk);
        Start = 1'b1; Pattern = 4'b0110; Count = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("busy_ready_low", {31'd0, Ready}, 32'd0);
        end
        Start = 1'b0;
        wait_idle("idle_t3");
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("no_second_xfer", {31'd0, Ready}, 32'd1);
        end

        // asynchronous reset midway through the second repeat
        n0 = n_done;
        start_xfer(4'b1010, 4'd3, ce);
        while (cyc < ce + 2 + PAT_W + G) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("arst_out", {31'd0, Out}, 32'd0);
        check("arst_valid", {31'd0, Out_valid}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_state", {30'd0, state}, 32'd0);
        q.delete();
        @(negedge Clk);
        @(negedge Clk);
        #3 Rst = 1'b1;
        @(negedge Clk);
        check("arst_no_done", n_done - n0, 32'd0);
        start_xfer(4'b1100, 4'd1, ce);
        wait_idle("idle_t4");

        // maximum count
        v0 = n_valid; n0 = n_done;
        start_xfer(4'b1001, 4'd15, ce);
        wait_idle("idle_t5");
        repeat (3) @(negedge Clk);
        check("max_bits", n_valid - v0, 32'd60);
        check("max_done_count", n_done - n0, 32'd1);

        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
